// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   - register offsets (decoded from Addr[3:2])
//   - STATUS / CTRL bit positions
//   - transmitter state enum
//   - reset value of the baud divisor and the effective-divisor helper
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_EMPTY = 5;
    localparam int ST_FULL  = 6;
    localparam int ST_BUSY  = 7;
    localparam int ST_OVF   = 8;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    localparam logic [15:0] DIV_RST_DEFAULT = 16'd434;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // A programmed divisor of 0 behaves like 1 (one clock per bit).
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// tx_fifo: byte FIFO feeding the transmitter.
//   clk, reset : system clock, synchronous active-high reset
//   push, din  : write request and byte; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head byte (valid when not empty)
//   count      : number of stored bytes (0..DEPTH)
//   full/empty : occupancy flags
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [4:0] count,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + 5'(do_push) - 5'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped UART transmitter (8N1) with TX FIFO.
//   clk, reset : system clock, synchronous active-high reset
//   Addr[31:2] : word address; Addr[3:2] selects TXDATA/STATUS/CTRL/DIV
//   WE, Din    : write strobe and data
//   Dout       : combinational read data
//   IRQ        : level interrupt (IE & FIFO empty & transmitter idle)
//   txd        : registered serial output, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] DIV_RST = DIV_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    tx_state_t   state, state_nx;
    logic        en, ie, overflow;
    logic [15:0] div_reg;
    logic [15:0] div_lat, div_lat_nx;
    logic [15:0] baud_cnt, baud_cnt_nx;
    logic [2:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        txd_nx;
    logic        launch;

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [4:0]  fifo_count;

    logic [1:0]  reg_sel;
    logic        wr_tx, wr_status, wr_ctrl, wr_div;
    logic        unused_bits;

    assign reg_sel     = Addr[3:2];
    assign wr_tx       = WE && (reg_sel == REG_TXDATA);
    assign wr_status   = WE && (reg_sel == REG_STATUS);
    assign wr_ctrl     = WE && (reg_sel == REG_CTRL);
    assign wr_div      = WE && (reg_sel == REG_DIV);
    assign unused_bits = ^{Addr[31:4], Din[31:16]};

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .din   (Din[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Register file
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            div_reg  <= DIV_RST;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en <= Din[CTRL_EN];
                ie <= Din[CTRL_IE];
            end
            if (wr_div) div_reg <= Din[15:0];
            // A push is dropped only when full and no pop frees a slot.
            if (wr_tx && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (wr_status && Din[ST_OVF])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        Dout = '0;
        case (reg_sel)
            REG_STATUS: begin
                Dout[4:0]      = fifo_count;
                Dout[ST_EMPTY] = fifo_empty;
                Dout[ST_FULL]  = fifo_full;
                Dout[ST_BUSY]  = (state != S_IDLE);
                Dout[ST_OVF]   = overflow;
            end
            REG_CTRL: begin
                Dout[CTRL_EN] = en;
                Dout[CTRL_IE] = ie;
            end
            REG_DIV:  Dout[15:0] = div_reg;
            default:  Dout = '0;
        endcase
    end

    assign IRQ = ie && fifo_empty && (state == S_IDLE);

    // Transmit FSM: state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            div_lat  <= eff_div(DIV_RST);
        end else begin
            state    <= state_nx;
            txd      <= txd_nx;
            shreg    <= shreg_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            div_lat  <= div_lat_nx;
        end
    end

    // Next state. The divisor is latched only when a frame is launched, so a
    // DIV write never stretches or shortens a frame already on the line.
    always_comb begin
        state_nx    = state;
        txd_nx      = txd;
        shreg_nx    = shreg;
        baud_cnt_nx = baud_cnt;
        bit_cnt_nx  = bit_cnt;
        div_lat_nx  = div_lat;
        fifo_pop    = 1'b0;
        launch      = 1'b0;

        case (state)
            S_IDLE: begin
                if (en && !fifo_empty) launch = 1'b1;
            end
            S_START: begin
                if (baud_cnt == 16'd0) begin
                    state_nx    = S_DATA;
                    baud_cnt_nx = div_lat - 16'd1;
                    bit_cnt_nx  = 3'd0;
                    txd_nx      = shreg[0];
                    shreg_nx    = shreg >> 1;
                end else begin
                    baud_cnt_nx = baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_nx = div_lat - 16'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = S_STOP;
                        txd_nx   = 1'b1;
                    end else begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        txd_nx     = shreg[0];
                        shreg_nx   = shreg >> 1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_cnt == 16'd0) begin
                    if (en && !fifo_empty) launch = 1'b1;
                    else                   state_nx = S_IDLE;
                end else begin
                    baud_cnt_nx = baud_cnt - 16'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Frame launch is shared by IDLE and the end of STOP (back-to-back).
        if (launch) begin
            fifo_pop    = 1'b1;
            shreg_nx    = fifo_dout;
            div_lat_nx  = eff_div(div_reg);
            baud_cnt_nx = eff_div(div_reg) - 16'd1;
            state_nx    = S_START;
            txd_nx      = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed testbench for uart_tx (DEPTH=4, DIV_RST=434).
module tb_uart_tx;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WE = 1'b0;
    logic [31:2] Addr = '0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    localparam logic [29:0] BASE = 30'h1FC8;  // byte address 0x7F20

    uart_tx #(.DEPTH(4), .DIV_RST(16'd434)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sel(input logic [1:0] r);
        Addr = BASE + 30'(r);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        sel(r);
        Din = d;
        WE  = 1'b1;
        @(negedge clk);
        WE  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        WE = 1'b0;
        sel(r);
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        WE    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the first negedge where txd is low (start bit sample 0).
    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        WE = 1'b0;
        sel(REG_STATUS);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    // Checks every cycle of one frame; caller is already on sample 0.
    // Optionally issues one register write on sample wr_at.
    task automatic check_frame(input logic [7:0] b, input int div, input int wr_at,
                               input logic [1:0] wr_reg, input logic [31:0] wr_val,
                               input string name);
        logic exp;
        int   slot;
        for (int i = 0; i < 10 * div; i++) begin
            if (i > 0) @(negedge clk);
            if (i == wr_at + 1) begin
                WE = 1'b0;
                sel(REG_STATUS);
                #1;
            end
            slot = i / div;
            if (slot == 0)      exp = 1'b0;
            else if (slot == 9) exp = 1'b1;
            else                exp = b[slot-1];
            chk($sformatf("%s_txd_%0d", name, i), 32'(txd), 32'(exp));
            if (i == 5 * div) begin
                chk({name, "_busy_mid"}, 32'(Dout[7]), 32'd1);
                chk({name, "_irq_mid"}, 32'(IRQ), 32'd0);
            end
            if (i == wr_at) begin
                sel(wr_reg);
                Din = wr_val;
                WE  = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int          low_seen;

        // Reset state
        do_reset();
        rd(REG_STATUS, v); chk("rst_status", v, 32'h20);
        rd(REG_CTRL, v);   chk("rst_ctrl", v, 32'h0);
        rd(REG_DIV, v);    chk("rst_div", v, 32'd434);
        rd(REG_TXDATA, v); chk("rst_txdata_rd", v, 32'h0);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(IRQ), 32'd0);

        // CTRL only keeps EN/IE
        wr(REG_CTRL, 32'hFFFF_FFFF);
        rd(REG_CTRL, v);   chk("ctrl_mask", v, 32'h3);
        wr(REG_CTRL, 32'h0);

        // Single frame, DIV=4, 0xA5
        wr(REG_DIV, 32'd4);
        wr(REG_CTRL, 32'h1);
        wr(REG_TXDATA, 32'hA5);
        wait_start("a5");
        check_frame(8'hA5, 4, -10, REG_STATUS, 32'h0, "a5");
        @(negedge clk);
        rd(REG_STATUS, v); chk("a5_status_after", v, 32'h20);
        chk("a5_txd_after", 32'(txd), 32'd1);

        // Overflow, W1C, FIFO order, EN cleared mid-frame
        do_reset();
        wr(REG_DIV, 32'd2);
        wr(REG_TXDATA, 32'h11);
        wr(REG_TXDATA, 32'h22);
        wr(REG_TXDATA, 32'h33);
        wr(REG_TXDATA, 32'h44);
        wr(REG_TXDATA, 32'h55);
        rd(REG_STATUS, v); chk("ovf_status", v, 32'h144);
        wr(REG_STATUS, 32'h0FF);
        rd(REG_STATUS, v); chk("ovf_keep", v, 32'h144);
        wr(REG_STATUS, 32'h100);
        rd(REG_STATUS, v); chk("ovf_clear", v, 32'h044);
        wr(REG_CTRL, 32'h1);
        wait_start("f11");
        check_frame(8'h11, 2, 4, REG_CTRL, 32'h0, "f11");
        @(negedge clk);
        rd(REG_STATUS, v); chk("en_off_status", v, 32'h003);
        chk("en_off_txd", 32'(txd), 32'd1);
        repeat (6) @(negedge clk);
        rd(REG_STATUS, v); chk("en_off_hold", v, 32'h003);
        chk("en_off_txd_hold", 32'(txd), 32'd1);

        // Back-to-back frames, DIV=2
        do_reset();
        wr(REG_DIV, 32'd2);
        wr(REG_TXDATA, 32'h01);
        wr(REG_TXDATA, 32'h02);
        wr(REG_CTRL, 32'h1);
        wait_start("b1");
        check_frame(8'h01, 2, -10, REG_STATUS, 32'h0, "b1");
        @(negedge clk);
        check_frame(8'h02, 2, -10, REG_STATUS, 32'h0, "b2");
        @(negedge clk);
        rd(REG_STATUS, v); chk("b2b_status_after", v, 32'h20);
        chk("b2b_txd_after", 32'(txd), 32'd1);

        // Interrupt, DIV=3
        do_reset();
        wr(REG_DIV, 32'd3);
        wr(REG_CTRL, 32'h3);
        chk("irq_idle_empty", 32'(IRQ), 32'd1);
        wr(REG_TXDATA, 32'h5A);
        wait_start("irq");
        check_frame(8'h5A, 3, -10, REG_STATUS, 32'h0, "irq");
        @(negedge clk);
        chk("irq_after_frame", 32'(IRQ), 32'd1);
        wr(REG_CTRL, 32'h1);
        chk("irq_ie_off", 32'(IRQ), 32'd0);

        // DIV change mid-frame applies to the next frame only
        do_reset();
        wr(REG_DIV, 32'd4);
        wr(REG_TXDATA, 32'h3C);
        wr(REG_TXDATA, 32'hC3);
        wr(REG_CTRL, 32'h1);
        wait_start("d4");
        check_frame(8'h3C, 4, 8, REG_DIV, 32'd8, "d4");
        @(negedge clk);
        check_frame(8'hC3, 8, -10, REG_STATUS, 32'h0, "d8");
        @(negedge clk);
        rd(REG_STATUS, v); chk("div_status_after", v, 32'h20);
        rd(REG_DIV, v);    chk("div_readback", v, 32'd8);

        // DIV=0 behaves as 1
        do_reset();
        wr(REG_DIV, 32'd0);
        rd(REG_DIV, v);    chk("div0_readback", v, 32'd0);
        wr(REG_CTRL, 32'h1);
        wr(REG_TXDATA, 32'h96);
        wait_start("d0");
        check_frame(8'h96, 1, -10, REG_STATUS, 32'h0, "d0");
        @(negedge clk);
        rd(REG_STATUS, v); chk("div0_status_after", v, 32'h20);

        // Reset in DATA aborts the frame
        do_reset();
        wr(REG_DIV, 32'd4);
        wr(REG_CTRL, 32'h1);
        wr(REG_TXDATA, 32'h00);
        wait_start("abort");
        repeat (10) @(negedge clk);
        chk("abort_txd_data", 32'(txd), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_txd", 32'(txd), 32'd1);
        rd(REG_STATUS, v); chk("abort_status", v, 32'h20);
        rd(REG_CTRL, v);   chk("abort_ctrl", v, 32'h0);
        rd(REG_DIV, v);    chk("abort_div", v, 32'd434);
        chk("abort_irq", 32'(IRQ), 32'd0);
        reset = 1'b0;
        low_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd !== 1'b1) low_seen++;
        end
        chk("abort_line_idle", 32'(low_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
